// File: rtl/avalon_aes_master.sv
// avalon_aes_master
// Hardware sequencer for the AES decryption peripheral. It accepts one
// key/ciphertext job at a time and issues one Avalon-MM transaction per cycle:
//   clear start -> key words -> ciphertext words -> set start -> poll done
//   -> read plaintext words -> clear start -> result pulse.
// A job whose done bit never appears within POLL_LIMIT polls is reported with
// RESULT_ERR set, and the previous plaintext is kept.
module avalon_aes_master #(
  parameter int POLL_LIMIT = 1024
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         JOB_START,
  input  logic [127:0] JOB_KEY,
  input  logic [127:0] JOB_MSG_ENC,
  output logic         BUSY,
  output logic         RESULT_VALID,
  output logic [127:0] RESULT_DEC,
  output logic         RESULT_ERR,
  output logic         AVL_READ,
  output logic         AVL_WRITE,
  output logic         AVL_CS,
  output logic [3:0]   AVL_BYTE_EN,
  output logic [3:0]   AVL_ADDR,
  output logic [31:0]  AVL_WRITEDATA,
  input  logic [31:0]  AVL_READDATA,
  input  logic         AVL_WAITREQUEST
);

  localparam int            CW         = $clog2(POLL_LIMIT + 1);
  localparam logic [CW-1:0] LAST_POLL  = CW'(POLL_LIMIT - 1);
  localparam logic [3:0]    ADDR_START = 4'd14;
  localparam logic [3:0]    ADDR_DONE  = 4'd15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRECLR,
    S_WR_KEY,
    S_WR_MSG,
    S_WR_START,
    S_POLL,
    S_RD_RES,
    S_POSTCLR,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    r_idx;
  logic [1:0]    w_idx_next;
  logic [CW-1:0] r_poll_cnt;
  logic [CW-1:0] w_poll_cnt_next;
  logic          r_err;
  logic          w_err_next;
  logic [127:0]  r_key;
  logic [127:0]  r_msg;
  logic [31:0]   r_res_word [4];
  logic          r_result_err;

  logic [31:0]   w_key_word [4];
  logic [31:0]   w_msg_word [4];
  logic          w_accept;
  logic          w_rd;
  logic          w_wr;
  logic          w_res_load;
  logic [3:0]    w_addr;
  logic [31:0]   w_wdata;

  assign w_accept = (r_state == S_IDLE) && JOB_START;

  // Word 0 of each 128-bit value is its most significant 32 bits.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
      assign w_key_word[gi] = r_key[127 - 32*gi -: 32];
      assign w_msg_word[gi] = r_msg[127 - 32*gi -: 32];
    end
  endgenerate

  // State, word index, poll counter, job inputs and the sticky error flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_poll_cnt   <= '0;
      r_err        <= 1'b0;
      r_key        <= '0;
      r_msg        <= '0;
      r_result_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_poll_cnt <= w_poll_cnt_next;
      r_err      <= w_err_next;
      if (w_accept) begin
        r_key <= JOB_KEY;
        r_msg <= JOB_MSG_ENC;
      end
      // The error output changes only as the completion pulse starts.
      if ((r_state == S_POSTCLR) && (w_state_next == S_DONE)) begin
        r_result_err <= r_err;
      end
    end
  end

  // Plaintext words are captured only on completed result reads.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 4; i++) begin
        r_res_word[i] <= '0;
      end
    end else if (w_res_load) begin
      r_res_word[r_idx] <= AVL_READDATA;
    end
  end

  // Next-state and bus command decode; a transaction advances only when not stalled.
  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx;
    w_poll_cnt_next = r_poll_cnt;
    w_err_next      = r_err;
    w_rd            = 1'b0;
    w_wr            = 1'b0;
    w_res_load      = 1'b0;
    w_addr          = 4'd0;
    w_wdata         = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (JOB_START) begin
          w_state_next = S_PRECLR;
          w_err_next   = 1'b0;
        end
      end
      S_PRECLR: begin
        w_wr   = 1'b1;
        w_addr = ADDR_START;
        if (!AVL_WAITREQUEST) begin
          w_state_next = S_WR_KEY;
          w_idx_next   = 2'd0;
        end
      end
      S_WR_KEY: begin
        w_wr    = 1'b1;
        w_addr  = {2'b00, r_idx};
        w_wdata = w_key_word[r_idx];
        if (!AVL_WAITREQUEST) begin
          w_idx_next = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_state_next = S_WR_MSG;
          end
        end
      end
      S_WR_MSG: begin
        w_wr    = 1'b1;
        w_addr  = {2'b01, r_idx};
        w_wdata = w_msg_word[r_idx];
        if (!AVL_WAITREQUEST) begin
          w_idx_next = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_state_next = S_WR_START;
          end
        end
      end
      S_WR_START: begin
        w_wr    = 1'b1;
        w_addr  = ADDR_START;
        w_wdata = 32'h1;
        if (!AVL_WAITREQUEST) begin
          w_state_next    = S_POLL;
          w_poll_cnt_next = '0;
        end
      end
      S_POLL: begin
        w_rd   = 1'b1;
        w_addr = ADDR_DONE;
        if (!AVL_WAITREQUEST) begin
          if (AVL_READDATA[0]) begin
            w_state_next = S_RD_RES;
            w_idx_next   = 2'd0;
          end else if (r_poll_cnt == LAST_POLL) begin
            w_state_next = S_POSTCLR;
            w_err_next   = 1'b1;
          end else begin
            w_poll_cnt_next = r_poll_cnt + CW'(1);
          end
        end
      end
      S_RD_RES: begin
        w_rd   = 1'b1;
        w_addr = {2'b10, r_idx};
        if (!AVL_WAITREQUEST) begin
          w_res_load = 1'b1;
          w_idx_next = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_state_next = S_POSTCLR;
          end
        end
      end
      S_POSTCLR: begin
        w_wr   = 1'b1;
        w_addr = ADDR_START;
        if (!AVL_WAITREQUEST) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign BUSY          = (r_state != S_IDLE);
  assign RESULT_VALID  = (r_state == S_DONE);
  assign RESULT_DEC    = {r_res_word[0], r_res_word[1], r_res_word[2], r_res_word[3]};
  assign RESULT_ERR    = r_result_err;
  assign AVL_READ      = w_rd;
  assign AVL_WRITE     = w_wr;
  assign AVL_CS        = w_rd | w_wr;
  assign AVL_BYTE_EN   = (w_rd | w_wr) ? 4'hF : 4'h0;
  assign AVL_ADDR      = w_addr;
  assign AVL_WRITEDATA = w_wdata;

endmodule
